mempool_dma_req_splitter: RTL
=============================

Name: mempool_dma_req_splitter

Overview:
- Frontend stage directly upstream of the group DMA backend.
- Accepts one DMA transfer request (id, src, dst, byte count, attributes) and emits a sequence of sub-transfers.
- No sub-transfer crosses a MaxChunkBytes-aligned boundary on either the source or the destination address.
- Keeps backend bursts within the AXI 4 KiB rule and L2/TCDM region granularity; attributes and id pass through unchanged.

Parameters:
- AddrWidth, 32, width of src/dst addresses and byte count.
- IdWidth, 2, request id width (matches the tile AXI id width).
- AttrWidth, 15, opaque pass-through bundle: cache_src, cache_dst, burst_src, burst_dst, decouple_rw, deburst, serialize.
- MaxChunkBytes, 4096, boundary and maximum chunk size; power of two, ≥ 4, ≤ 2^(AddrWidth-1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  1  incoming request valid.
- req_ready_o  out  1  request accepted when valid&&ready.
- req_id_i  in  IdWidth  request id.
- req_src_i  in  AddrWidth  source byte address.
- req_dst_i  in  AddrWidth  destination byte address.
- req_num_bytes_i  in  AddrWidth  total transfer length in bytes.
- req_attr_i  in  AttrWidth  pass-through attributes.
- chunk_valid_o  out  1  sub-transfer valid.
- chunk_ready_i  in  1  backend accepts sub-transfer.
- chunk_id_o  out  IdWidth  latched id.
- chunk_src_o  out  AddrWidth  chunk source address.
- chunk_dst_o  out  AddrWidth  chunk destination address.
- chunk_num_bytes_o  out  AddrWidth  chunk length.
- chunk_attr_o  out  AttrWidth  latched attributes.
- chunk_last_o  out  1  final chunk of the request.
- busy_o  out  1  request in progress.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous, active-low on rst_ni.
- Reset values:
  - State: IDLE.
  - req_ready_o = 1 (follows IDLE).
  - chunk_valid_o = 0, busy_o = 0.
  - All internal registers (id, src, dst, rem, attr) = 0, so every chunk_* data output reads 0.
- FSM IDLE:
  - req_ready_o = 1, chunk_valid_o = 0, busy_o = 0.
  - req_ready_o depends only on state, never on req_valid_i.
  - On req_valid_i: latch id, src, dst, attr, and rem = num_bytes; go to SPLIT.
- FSM SPLIT:
  - req_ready_o = 0, chunk_valid_o = 1, busy_o = 1.
  - Latency: first chunk_valid_o is asserted in the cycle after acceptance.
- Chunk length (combinational from registers):
  - src_room = MaxChunkBytes - (src & (MaxChunkBytes-1)).
  - dst_room = MaxChunkBytes - (dst & (MaxChunkBytes-1)).
  - len = min(rem, src_room, dst_room).
  - Comparisons are unsigned, AddrWidth+1 bits internally; no truncation.
  - chunk_last_o = (rem == len), i.e. rem ≤ both rooms.
- On chunk handshake (chunk_valid_o && chunk_ready_i):
  - If last: go to IDLE.
  - Else: src += len, dst += len, rem -= len.
  - Address arithmetic wraps modulo 2^AddrWidth.
- Back-to-back requests: one bubble cycle.
  - req_ready_o rises in the cycle after the last-chunk handshake; it is not combinationally reopened.
- Zero-length request (num_bytes = 0): emits exactly one chunk with len = 0, last = 1, original src/dst, so completion tracking per id stays intact.
- Output stability: while chunk_valid_o && !chunk_ready_i, every chunk_* output holds stable. valid never drops without a handshake.
- chunk_ready_i asserted while in IDLE is ignored.
- Reset asserted mid-transfer aborts immediately to the reset values. No further chunks of that request are emitted after reset.
- Chunk count for aligned src/dst: ceil(n / MaxChunkBytes). Misalignment adds at most one split per distinct boundary crossing.
- Assertions (simulation only):
  - MaxChunkBytes is a power of two.
  - No chunk crosses a boundary.
  - Sum of chunk lengths equals num_bytes.

Test Plan:
- Aligned split, Max=4096, src=0x1000, dst=0x8000, n=0x2000 → two chunks: (0x1000, 0x8000, 0x1000, last=0) then (0x2000, 0x9000, 0x1000, last=1); req_ready_o returns one cycle after.
- Src misaligned: src=0x0FF0, dst=0x3000, n=0x40 → (0x0FF0, 0x3000, 0x10, 0) then (0x1000, 0x3010, 0x30, 1).
- Both misaligned differently: src=0x0F00, dst=0x1F80, n=0x200 → (0x0F00, 0x1F80, 0x80, 0), (0x0F80, 0x2000, 0x80, 0), (0x1000, 0x2080, 0x100, 1).
- Backpressure plus zero length:
  - Hold chunk_ready_i=0 for 5 cycles on the first chunk → outputs stable, no advance.
  - Then n=0 at src=0x40 → a single chunk (0x40, dst, 0, last=1).
- Wrap and reset:
  - src=0xFFFF_FFF0, dst=0x0, n=0x20 → (0xFFFF_FFF0, 0x0, 0x10, 0) then (0x0000_0000, 0x10, 0x10, 1).
  - Separately, rst_ni low after the first chunk of a 3-chunk request → chunk_valid_o=0 and req_ready_o=1 asynchronously; no remaining chunks emitted.

Source files
------------

// File: rtl/mempool_dma_req_splitter.sv
// Splits one DMA request into sub-transfers that never cross a MaxChunkBytes
// boundary on either the source or the destination side.
//
// state | meaning
// IDLE  | ready for a new request, no chunk pending
// SPLIT | presenting chunks of the latched request until the last one is taken
module mempool_dma_req_splitter #(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned IdWidth       = 2,
  parameter int unsigned AttrWidth     = 15,
  parameter int unsigned MaxChunkBytes = 4096
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [IdWidth-1:0]   req_id_i,
  input  logic [AddrWidth-1:0] req_src_i,
  input  logic [AddrWidth-1:0] req_dst_i,
  input  logic [AddrWidth-1:0] req_num_bytes_i,
  input  logic [AttrWidth-1:0] req_attr_i,
  output logic                 chunk_valid_o,
  input  logic                 chunk_ready_i,
  output logic [IdWidth-1:0]   chunk_id_o,
  output logic [AddrWidth-1:0] chunk_src_o,
  output logic [AddrWidth-1:0] chunk_dst_o,
  output logic [AddrWidth-1:0] chunk_num_bytes_o,
  output logic [AttrWidth-1:0] chunk_attr_o,
  output logic                 chunk_last_o,
  output logic                 busy_o
);

  localparam logic [AddrWidth:0]   MaxChunk = (AddrWidth+1)'(MaxChunkBytes);
  localparam logic [AddrWidth-1:0] OffMask  = AddrWidth'(MaxChunkBytes - 1);

  typedef enum logic {IDLE, SPLIT} state_e;

  state_e               state_q, state_d;
  logic [IdWidth-1:0]   id_q;
  logic [AddrWidth-1:0] src_q, dst_q, rem_q;
  logic [AttrWidth-1:0] attr_q;
  logic [AddrWidth:0]   src_room, dst_room, len;
  logic                 last, handshake, accept;

  // One extra bit keeps a full MaxChunkBytes room representable without wrap.
  always_comb begin
    src_room = MaxChunk - {1'b0, src_q & OffMask};
    dst_room = MaxChunk - {1'b0, dst_q & OffMask};
    len      = {1'b0, rem_q};
    if (src_room < len) len = src_room;
    if (dst_room < len) len = dst_room;
  end

  assign last      = ({1'b0, rem_q} == len);
  assign accept    = (state_q == IDLE) && req_valid_i;
  assign handshake = (state_q == SPLIT) && chunk_ready_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid_i) state_d = SPLIT;
      SPLIT:   if (chunk_ready_i && last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_q   <= '0;
      src_q  <= '0;
      dst_q  <= '0;
      rem_q  <= '0;
      attr_q <= '0;
    end else if (accept) begin
      id_q   <= req_id_i;
      src_q  <= req_src_i;
      dst_q  <= req_dst_i;
      rem_q  <= req_num_bytes_i;
      attr_q <= req_attr_i;
    end else if (handshake && !last) begin
      src_q <= src_q + len[AddrWidth-1:0];
      dst_q <= dst_q + len[AddrWidth-1:0];
      rem_q <= rem_q - len[AddrWidth-1:0];
    end
  end

  assign req_ready_o       = (state_q == IDLE);
  assign chunk_valid_o     = (state_q == SPLIT);
  assign busy_o            = (state_q == SPLIT);
  assign chunk_id_o        = id_q;
  assign chunk_src_o       = src_q;
  assign chunk_dst_o       = dst_q;
  assign chunk_num_bytes_o = len[AddrWidth-1:0];
  assign chunk_attr_o      = attr_q;
  assign chunk_last_o      = last;

  if (((MaxChunkBytes & (MaxChunkBytes - 1)) != 0) || (MaxChunkBytes < 4)) begin : gen_bad_chunk
    $error("MaxChunkBytes must be a power of two and at least 4");
  end

`ifndef SYNTHESIS
  logic [AddrWidth-1:0] total_q, sent_q, chunk_end;

  assign chunk_end = src_q + len[AddrWidth-1:0] - AddrWidth'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      total_q <= '0;
      sent_q  <= '0;
    end else if (accept) begin
      total_q <= req_num_bytes_i;
      sent_q  <= '0;
    end else if (handshake) begin
      sent_q <= sent_q + len[AddrWidth-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && handshake) begin
      assert (len == '0 || ((src_q ^ chunk_end) & ~OffMask) == '0)
        else $error("chunk crosses a source boundary");
      assert (!last || (sent_q + len[AddrWidth-1:0]) == total_q)
        else $error("chunk lengths do not sum to the request length");
    end
  end
`endif

endmodule
